mult_host: RTL

- Host-side sequencer for the shared-databus shift-and-add multiplier. This block is the initiator end of that multiplier's interface.
- It accepts an operand pair from a local request interface and pulses start to the multiplier.
- It drives operand A, then operand B, onto the bidirectional 8-bit databus, then releases the bus.
- It captures the LSB and MSB product bytes as the multiplier drives them back, and returns a 16-bit product with a one-cycle valid pulse.

---
 rtl/mult_host.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mult_host.sv
// mult_host: initiator-side sequencer for the shared-databus shift-and-add multiplier.
// It latches an operand pair, pulses mul_start, drives A then B on the shared bus,
// collects the LSB/MSB product bytes in either order, and returns them with a valid pulse.
// Optional build macro: MULT_HOST_TIMEOUT_EN adds a WAIT-state watchdog that ends the
// operation after TIMEOUT_CYCLES with an all-ones product and err set.
module mult_host #(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy,
    output logic               valid,
    output logic [2*WIDTH-1:0] product,
    output logic               err,
    output logic               mul_start,
    inout  wire  [WIDTH-1:0]   mul_databus,
    input  logic               mul_lsb_out,
    input  logic               mul_msb_out,
    input  logic               mul_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DRV_A, S_DRV_B, S_WAIT, S_RESP
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_lsb;
    logic [WIDTH-1:0] r_msb;
    logic             r_lsb_cap;
    logic             r_msb_cap;

    logic             w_drv_phase;
    logic             w_contend;
    logic             w_drive;
    logic [WIDTH-1:0] w_bus_data;
    logic             w_lsb_cap;
    logic             w_msb_cap;
    logic [WIDTH-1:0] w_lsb_val;
    logic [WIDTH-1:0] w_msb_val;
    logic             w_complete;
    logic             w_expire;

    // Bus ownership: only in the two operand phases, and backed off at once if the
    // multiplier is also driving. rst_n gates the driver so reset frees the bus immediately.
    assign w_drv_phase = (r_state == S_DRV_A) || (r_state == S_DRV_B);
    assign w_contend   = mul_lsb_out | mul_msb_out;
    assign w_drive     = rst_n & w_drv_phase & ~w_contend;
    assign w_bus_data  = (r_state == S_DRV_A) ? r_a : r_b;
    assign mul_databus = w_drive ? w_bus_data : {WIDTH{1'bz}};

    // Capture view including this cycle's strobes, so a half arriving together with
    // mul_done still completes the operation in that cycle.
    assign w_lsb_cap  = r_lsb_cap | mul_lsb_out;
    assign w_msb_cap  = r_msb_cap | mul_msb_out;
    assign w_lsb_val  = mul_lsb_out ? mul_databus : r_lsb;
    assign w_msb_val  = mul_msb_out ? mul_databus : r_msb;
    assign w_complete = mul_done & w_lsb_cap & w_msb_cap;

`ifdef MULT_HOST_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_tmo;
    // Counter value TIMEOUT_CYCLES-1 marks the last allowed WAIT cycle.
    assign w_expire = ~w_complete && (r_tmo == CW'(TIMEOUT_CYCLES - 1));
`else
    assign w_expire = 1'b0;
`endif

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_lsb     <= '0;
            r_msb     <= '0;
            r_lsb_cap <= 1'b0;
            r_msb_cap <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            product   <= '0;
            err       <= 1'b0;
            mul_start <= 1'b0;
`ifdef MULT_HOST_TIMEOUT_EN
            r_tmo     <= '0;
`endif
        end else begin
            valid     <= 1'b0;
            mul_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_a       <= a_in;
                        r_b       <= b_in;
                        r_lsb_cap <= 1'b0;
                        r_msb_cap <= 1'b0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        mul_start <= 1'b1;
                        r_state   <= S_START;
                    end
                end
                S_START: r_state <= S_DRV_A;
                S_DRV_A: begin
                    if (w_contend) err <= 1'b1;
                    r_state <= S_DRV_B;
                end
                S_DRV_B: begin
                    if (w_contend) err <= 1'b1;
`ifdef MULT_HOST_TIMEOUT_EN
                    r_tmo <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_lsb_out) begin
                        r_lsb     <= mul_databus;
                        r_lsb_cap <= 1'b1;
                    end
                    if (mul_msb_out) begin
                        r_msb     <= mul_databus;
                        r_msb_cap <= 1'b1;
                    end
                    if (w_complete) begin
                        product <= {w_msb_val, w_lsb_val};
                        valid   <= 1'b1;
                        r_state <= S_RESP;
                    end else if (w_expire) begin
                        product <= '1;
                        err     <= 1'b1;
                        valid   <= 1'b1;
                        r_state <= S_RESP;
                    end
`ifdef MULT_HOST_TIMEOUT_EN
                    r_tmo <= r_tmo + 1'b1;
`endif
                end
                S_RESP: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
